// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants for the ID-stage branch hazard scheduler: forwarding source
// codes, Tuse/Tnew values and register-index ranges.
package branch_hazard_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int REG_IDX_MIN = 0;
    localparam int REG_IDX_MAX = 31;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_src_e;

    localparam int TUSE_NONE = 3;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LOAD = 2;

endpackage

// File: rtl/branch_hazard_ctrl_hazard_match.sv
// Youngest-writer search for one D-stage source operand across E, M and W.
// Returns whether a tracked stage writes the operand, which one, and its Tnew.
module hazard_match
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int TNEW_W = 2
) (
    input  logic [REG_IDX_W-1:0] src,
    input  logic [TNEW_W-1:0]    tuse,
    input  logic                 e_valid,
    input  logic [REG_IDX_W-1:0] e_dst,
    input  logic [TNEW_W-1:0]    e_tnew,
    input  logic                 m_valid,
    input  logic [REG_IDX_W-1:0] m_dst,
    input  logic [TNEW_W-1:0]    m_tnew,
    input  logic                 w_valid,
    input  logic [REG_IDX_W-1:0] w_dst,
    input  logic [TNEW_W-1:0]    w_tnew,
    output logic                 hit,
    output fwd_src_e             stage,
    output logic [TNEW_W-1:0]    tnew
);

    always_comb begin
        hit   = 1'b0;
        stage = FWD_RF;
        tnew  = '0;
        // $0 and unused operands never take part in a match.
        if (src != REG_ZERO && tuse != TNEW_W'(TUSE_NONE)) begin
            if (e_valid && e_dst == src) begin
                hit   = 1'b1;
                stage = FWD_E;
                tnew  = e_tnew;
            end else if (m_valid && m_dst == src) begin
                hit   = 1'b1;
                stage = FWD_M;
                tnew  = m_tnew;
            end else if (w_valid && w_dst == src) begin
                hit   = 1'b1;
                stage = FWD_W;
                tnew  = w_tnew;
            end
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Tnew/Tuse stall and forwarding control for the ID-stage branch comparator.
// Optional BRANCH_HAZARD_PERF_EN adds free-running stall and taken-branch counters.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int TNEW_W = 2,
    parameter int NSTAGE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [REG_IDX_W-1:0] d_rs,
    input  logic [REG_IDX_W-1:0] d_rt,
    input  logic [TNEW_W-1:0]    d_tuse_rs,
    input  logic [TNEW_W-1:0]    d_tuse_rt,
    input  logic [REG_IDX_W-1:0] d_dst,
    input  logic [TNEW_W-1:0]    d_tnew,
    input  logic                 flush,
    input  logic                 br_raw,
    output logic                 stall,
    output logic [1:0]           fwd_rs,
    output logic [1:0]           fwd_rt,
    output logic                 br_take
`ifdef BRANCH_HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          br_cnt
`endif
);

    // Index 0 = E, 1 = M, 2 = W.
    logic                 valid_q [NSTAGE];
    logic [REG_IDX_W-1:0] dst_q   [NSTAGE];
    logic [TNEW_W-1:0]    tnew_q  [NSTAGE];
    logic                 valid_d [NSTAGE];
    logic [REG_IDX_W-1:0] dst_d   [NSTAGE];
    logic [TNEW_W-1:0]    tnew_d  [NSTAGE];

    logic              hit_rs, hit_rt;
    fwd_src_e          stage_rs, stage_rt;
    logic [TNEW_W-1:0] tnew_rs, tnew_rt;
    logic              stall_rs, stall_rt;

    function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    hazard_match #(.TNEW_W(TNEW_W)) u_match_rs (
        .src     (d_rs),
        .tuse    (d_tuse_rs),
        .e_valid (valid_q[0]), .e_dst (dst_q[0]), .e_tnew (tnew_q[0]),
        .m_valid (valid_q[1]), .m_dst (dst_q[1]), .m_tnew (tnew_q[1]),
        .w_valid (valid_q[2]), .w_dst (dst_q[2]), .w_tnew (tnew_q[2]),
        .hit     (hit_rs),
        .stage   (stage_rs),
        .tnew    (tnew_rs)
    );

    hazard_match #(.TNEW_W(TNEW_W)) u_match_rt (
        .src     (d_rt),
        .tuse    (d_tuse_rt),
        .e_valid (valid_q[0]), .e_dst (dst_q[0]), .e_tnew (tnew_q[0]),
        .m_valid (valid_q[1]), .m_dst (dst_q[1]), .m_tnew (tnew_q[1]),
        .w_valid (valid_q[2]), .w_dst (dst_q[2]), .w_tnew (tnew_q[2]),
        .hit     (hit_rt),
        .stage   (stage_rt),
        .tnew    (tnew_rt)
    );

    assign stall_rs = d_valid && hit_rs && (tnew_rs > d_tuse_rs);
    assign stall_rt = d_valid && hit_rt && (tnew_rt > d_tuse_rt);
    assign stall    = stall_rs || stall_rt;

    // A stalling operand always has tnew > 0, so it falls through to FWD_RF.
    assign fwd_rs  = (hit_rs && tnew_rs == '0) ? stage_rs : FWD_RF;
    assign fwd_rt  = (hit_rt && tnew_rt == '0) ? stage_rt : FWD_RF;
    assign br_take = br_raw && d_valid && !stall;

    always_comb begin
        for (int s = 1; s < NSTAGE; s++) begin
            valid_d[s] = valid_q[s-1];
            dst_d[s]   = dst_q[s-1];
            tnew_d[s]  = dec_sat(tnew_q[s-1]);
        end
        if (stall) begin
            valid_d[0] = 1'b0;
            dst_d[0]   = REG_ZERO;
            tnew_d[0]  = '0;
        end else begin
            valid_d[0] = d_valid;
            dst_d[0]   = d_dst;
            tnew_d[0]  = d_tnew;
        end
        // Flush outranks both advance and stall: every tracked stage empties.
        if (flush) begin
            for (int s = 0; s < NSTAGE; s++) begin
                valid_d[s] = 1'b0;
                dst_d[s]   = REG_ZERO;
                tnew_d[s]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSTAGE; s++) begin
                valid_q[s] <= 1'b0;
                dst_q[s]   <= REG_ZERO;
                tnew_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NSTAGE; s++) begin
                valid_q[s] <= valid_d[s];
                dst_q[s]   <= dst_d[s];
                tnew_q[s]  <= tnew_d[s];
            end
        end
    end

`ifdef BRANCH_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] br_cnt_q, br_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        br_cnt_d    = br_cnt_q + {31'd0, br_take};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            br_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            br_cnt_q    <= br_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign br_cnt    = br_cnt_q;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed pipeline scenarios plus random traffic
// checked against a list-of-stages reference model.
module tb_branch_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       flush, br_raw;
    logic       stall, br_take;
    logic [1:0] fwd_rs, fwd_rt;
`ifdef BRANCH_HAZARD_PERF_EN
    logic [31:0] stall_cnt, br_cnt;
    int          m_stall_cnt, m_br_cnt;
`endif

    int n_tests, n_fail;

    // Reference pipeline: index 0 = E, 1 = M, 2 = W.
    int mv[3], md[3], mt[3];

    branch_hazard_ctrl #(.TNEW_W(2), .NSTAGE(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_dst     (d_dst),
        .d_tnew    (d_tnew),
        .flush     (flush),
        .br_raw    (br_raw),
        .stall     (stall),
        .fwd_rs    (fwd_rs),
        .fwd_rt    (fwd_rt),
        .br_take   (br_take)
`ifdef BRANCH_HAZARD_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .br_cnt    (br_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int youngest(input int x, input int tuse);
        if (x == 0 || tuse == 3) return -1;
        for (int s = 0; s < 3; s++)
            if (mv[s] != 0 && md[s] == x) return s;
        return -1;
    endfunction

    task automatic model_eval(output int e_stall, output int e_frs, output int e_frt, output int e_br);
        int srs, srt, st_rs, st_rt;
        srs   = youngest(int'(d_rs), int'(d_tuse_rs));
        srt   = youngest(int'(d_rt), int'(d_tuse_rt));
        st_rs = (d_valid && srs >= 0 && mt[srs] > int'(d_tuse_rs)) ? 1 : 0;
        st_rt = (d_valid && srt >= 0 && mt[srt] > int'(d_tuse_rt)) ? 1 : 0;
        e_stall = (st_rs != 0 || st_rt != 0) ? 1 : 0;
        e_frs = (srs >= 0 && mt[srs] == 0) ? srs + 1 : 0;
        e_frt = (srt >= 0 && mt[srt] == 0) ? srt + 1 : 0;
        e_br  = (br_raw && d_valid && e_stall == 0) ? 1 : 0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            mv[s] = 0; md[s] = 0; mt[s] = 0;
        end
`ifdef BRANCH_HAZARD_PERF_EN
        m_stall_cnt = 0;
        m_br_cnt    = 0;
`endif
    endtask

    task automatic check_model(input string tag);
        int es, efr, eft, eb;
        model_eval(es, efr, eft, eb);
        chk({tag, "_stall"},  32'(stall),   32'(es));
        chk({tag, "_fwd_rs"}, 32'(fwd_rs),  32'(efr));
        chk({tag, "_fwd_rt"}, 32'(fwd_rt),  32'(eft));
        chk({tag, "_br"},     32'(br_take), 32'(eb));
`ifdef BRANCH_HAZARD_PERF_EN
        chk({tag, "_scnt"},   stall_cnt,    32'(m_stall_cnt));
        chk({tag, "_bcnt"},   br_cnt,       32'(m_br_cnt));
`endif
    endtask

    task automatic apply(input int v, input int rs, input int rt, input int urs, input int urt,
                         input int dst, input int tn, input int fl, input int br);
        @(negedge clk);
        d_valid   = (v != 0);
        d_rs      = 5'(rs);
        d_rt      = 5'(rt);
        d_tuse_rs = 2'(urs);
        d_tuse_rt = 2'(urt);
        d_dst     = 5'(dst);
        d_tnew    = 2'(tn);
        flush     = (fl != 0);
        br_raw    = (br != 0);
        #1;
    endtask

    task automatic tick();
        int es, efr, eft, eb;
        model_eval(es, efr, eft, eb);
        @(posedge clk);
        if (flush) begin
            for (int s = 0; s < 3; s++) begin
                mv[s] = 0; md[s] = 0; mt[s] = 0;
            end
        end else begin
            for (int s = 2; s >= 1; s--) begin
                mv[s] = mv[s-1];
                md[s] = md[s-1];
                mt[s] = (mt[s-1] > 0) ? mt[s-1] - 1 : 0;
            end
            mv[0] = (es != 0) ? 0 : int'(d_valid);
            md[0] = (es != 0) ? 0 : int'(d_dst);
            mt[0] = (es != 0) ? 0 : int'(d_tnew);
        end
`ifdef BRANCH_HAZARD_PERF_EN
        m_stall_cnt += es;
        m_br_cnt    += eb;
`endif
    endtask

    task automatic do_flush();
        apply(0, 0, 0, 3, 3, 0, 0, 1, 0);
        check_model("flush");
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        d_valid = 1'b0; d_rs = '0; d_rt = '0; d_dst = '0;
        d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_tnew = '0;
        flush = 1'b0; br_raw = 1'b0;
        model_clear();
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_rs", 32'(fwd_rs), 0);
        chk("rst_fwd_rt", 32'(fwd_rt), 0);
        chk("rst_br", 32'(br_take), 0);
        @(negedge clk);
        reset = 1'b0;

        // lw $t0 ; beq $t0,$t1 : two stall cycles, then forward from W.
        apply(1, 29, 0, 1, 3, 8, 2, 0, 0); check_model("lw"); tick();
        apply(1, 8, 9, 0, 0, 0, 0, 0, 1);
        chk("lw_stall1", 32'(stall), 1); chk("lw_br1", 32'(br_take), 0);
        check_model("lw_beq1"); tick();
        apply(1, 8, 9, 0, 0, 0, 0, 0, 1);
        chk("lw_stall2", 32'(stall), 1); chk("lw_br2", 32'(br_take), 0);
        check_model("lw_beq2"); tick();
        apply(1, 8, 9, 0, 0, 0, 0, 0, 1);
        chk("lw_stall3", 32'(stall), 0); chk("lw_fwd_w", 32'(fwd_rs), 3);
        chk("lw_br3", 32'(br_take), 1);
        check_model("lw_beq3"); tick();

        // addu $t2 ; bne $t2,$0 : one stall cycle, then forward from M.
        do_flush();
        apply(1, 17, 18, 1, 1, 10, 1, 0, 0); check_model("addu"); tick();
        apply(1, 10, 0, 0, 0, 0, 0, 0, 1);
        chk("alu_stall1", 32'(stall), 1); check_model("alu_bne1"); tick();
        apply(1, 10, 0, 0, 0, 0, 0, 0, 1);
        chk("alu_stall2", 32'(stall), 0); chk("alu_fwd_m", 32'(fwd_rs), 2);
        chk("alu_br", 32'(br_take), 1); check_model("alu_bne2"); tick();
        apply(1, 17, 18, 1, 1, 19, 1, 0, 0);
        chk("alu_br_once", 32'(br_take), 0); check_model("alu_next"); tick();

        // lui $t3 ; addu ; blez $t3 : no stall, forward from M.
        do_flush();
        apply(1, 0, 0, 3, 3, 11, 0, 0, 0); check_model("lui"); tick();
        apply(1, 17, 18, 1, 1, 13, 1, 0, 0); check_model("lui_addu"); tick();
        apply(1, 11, 0, 0, 3, 0, 0, 0, 0);
        chk("lui_stall", 32'(stall), 0); chk("lui_fwd_m", 32'(fwd_rs), 2);
        check_model("lui_blez"); tick();

        // addu $0 ; beq $0,$0 : $0 never matches.
        do_flush();
        apply(1, 17, 18, 1, 1, 0, 1, 0, 0); check_model("wr0"); tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("r0_stall", 32'(stall), 0); chk("r0_fwd_rs", 32'(fwd_rs), 0);
        chk("r0_fwd_rt", 32'(fwd_rt), 0); check_model("r0_beq"); tick();

        // Two writers of $t4: the youngest (E, tnew 1) governs.
        do_flush();
        apply(1, 0, 0, 3, 3, 12, 0, 0, 0); check_model("t4_lui"); tick();
        apply(1, 17, 18, 1, 1, 12, 1, 0, 0); check_model("t4_addu"); tick();
        apply(1, 12, 9, 0, 0, 0, 0, 0, 1);
        chk("yng_stall", 32'(stall), 1); check_model("yng_beq1"); tick();
        apply(1, 12, 9, 0, 0, 0, 0, 0, 1);
        chk("yng_fwd_m", 32'(fwd_rs), 2); check_model("yng_beq2"); tick();

        // Flush during a load stall empties every stage.
        do_flush();
        apply(1, 29, 0, 1, 3, 8, 2, 0, 0); check_model("fl_lw"); tick();
        apply(1, 8, 9, 0, 0, 0, 0, 1, 1);
        chk("fl_stall_pre", 32'(stall), 1); check_model("fl_beq"); tick();
        apply(1, 8, 9, 0, 0, 0, 0, 0, 1);
        chk("fl_stall_post", 32'(stall), 0); chk("fl_fwd", 32'(fwd_rs), 0);
        check_model("fl_after"); tick();

        // Reset pulsed mid-stall drops stall without a clock edge.
        apply(1, 29, 0, 1, 3, 8, 2, 0, 0); check_model("rs_lw"); tick();
        apply(1, 8, 9, 0, 0, 0, 0, 0, 1);
        chk("rs_stall_pre", 32'(stall), 1);
        reset = 1'b1;
        #1;
        chk("rs_stall_async", 32'(stall), 0);
        chk("rs_br_async", 32'(br_take), 1);
        model_clear();
        reset = 1'b0;
        #1;
        check_model("rs_after"); tick();

        // Random traffic over a small register set to provoke frequent hits.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 8) != 0 ? 1 : 0, $urandom % 4, $urandom % 4,
                  $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 3,
                  ($urandom % 16) == 0 ? 1 : 0, $urandom % 2);
            check_model("rnd");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Tnew/Tuse hazard scheduler for the ID-stage branch comparator in the 5-stage MIPS pipeline.
- Tracks the destination register and remaining Tnew of the instructions in the E, M and W stages.
- Asserts stall when a source operand of the D-stage instruction is not yet produced, and selects the forwarding source for both D-stage operands.
- Gates the branch comparator's ifBr so that no redirect is taken from stale operands.

Parameters:
- TNEW_W, 2, width of the Tnew/Tuse fields in cycles.
- NSTAGE, 3, number of tracked downstream stages (E, M, W); fixed at 3 in this revision.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  D stage holds a real instruction.
- d_rs  in  5  rs index of the D-stage instruction.
- d_rt  in  5  rt index of the D-stage instruction.
- d_tuse_rs  in  TNEW_W  cycles until rs is consumed (0 for branches/jr); 3 means unused.
- d_tuse_rt  in  TNEW_W  same for rt.
- d_dst  in  5  register written by the D-stage instruction (0 = none).
- d_tnew  in  TNEW_W  cycles after entering E until the result exists (0 for lui-class, 1 for ALU, 2 for loads).
- flush  in  1  synchronous pipeline flush (exception/eret); clears all tracked stages.
- br_raw  in  1  raw ifBr from the branch comparator.
- stall  out  1  freeze PC and F/D; a bubble enters E.
- fwd_rs  out  2  rs source: 0 regfile, 1 E, 2 M, 3 W.
- fwd_rt  out  2  rt source, same encoding.
- br_take  out  1  br_raw qualified by d_valid and not stall.

Behaviour:
- Reset: all stage entries dst=0, tnew=0, valid=0. Outputs: stall=0, fwd_rs=fwd_rt=0, br_take=0.
- Per-stage state: {valid, dst[4:0], tnew}, for E, M and W.
- Advance, every clk edge with reset low:
  - W <= M.
  - M <= E.
  - tnew decrements by 1 on each move and saturates at 0.
- E load:
  - E <= {d_valid, d_dst, d_tnew} when !stall and !flush.
  - E <= bubble (valid=0, dst=0) when stall.
- Flush: E, M and W all become bubbles on that edge; flush has priority over stall.
- Match rule, per operand X in {rs, rt}:
  - Only considered if X != 0 and tuse_X != 3.
  - Find the youngest stage S (E, then M, then W) with valid and dst==X.
  - Only the youngest match counts; older matches are ignored.
- stall = d_valid && (for rs or rt, the youngest match has tnew_S > tuse_X). Combinational, zero latency.
- fwd_X:
  - The youngest match's stage code when that stage's tnew==0.
  - 0 when there is no match.
  - Don't-care (driven to 0) when that operand causes the stall.
- br_take = br_raw && d_valid && !stall; combinational.
- Register $0 never matches, so a write to $0 never stalls or forwards.
- A load in E followed by beq using its result stalls 2 cycles (tnew 2→1→0 reaches M→W), then forwards from W.
- An ALU result followed by a branch on it stalls 1 cycle, then forwards from M.
- Reset asserted mid-stall clears all state immediately; stall drops asynchronously with it.

Optional Feature:
- Macro: BRANCH_HAZARD_PERF_EN.
- Defined:
  - Adds 32-bit outputs stall_cnt and br_cnt.
  - stall_cnt increments each cycle stall=1; br_cnt increments each cycle br_take=1.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: the ports and counters do not exist; the rest of the block is unchanged.

Decomposition:
- Shared settings include provides:
  - Stage code constants FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TUSE_NONE=3.
  - Tnew constants for ALU=1 and LOAD=2.
  - Register-index range macros.
- One sub-module, hazard_match: per-operand youngest-match search returning {hit, stage, tnew}; instantiated twice (rs, rt).

Test Plan:
- lw $t0 then beq $t0,$t1: stall=1 for 2 cycles, then fwd_rs=3. br_take follows br_raw only after the stall drops.
- addu $t2 then bne $t2,$0: 1 stall cycle, then fwd_rs=2. With RData1≠0, br_take=1 for exactly one cycle.
- lui $t3 then addu, then blez $t3: no stall, fwd_rs=2 (M, tnew 0).
- addu $0 then beq $0,$0: stall=0, fwd_rs=fwd_rt=0.
- Two writers to $t4 in E (tnew 1) and M (tnew 0), then beq on $t4: the youngest (E) governs, stall=1. An older-stage-only match would not stall.
- flush during a load stall: next cycle all stages empty, stall=0, fwd=0. reset pulsed mid-stall: stall=0 asynchronously.
